// File: rtl/instr_mem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_fetch
// Purpose  : Byte-addressed instruction memory with a valid/ready fetch port.
//            Returns the big-endian word at req_pc one cycle after accept,
//            holds it under downstream stall, and flags misaligned or
//            out-of-range fetches. A word-load port writes program image.
// Ports    : clk, rst (sync, active-high)
//            load_en/load_addr/load_data -> image write, load_err pulse out
//            req_valid/req_pc/req_ready  -> fetch request handshake
//            rsp_valid/rsp_ready/rsp_instr/rsp_pc/rsp_fault -> response
//            fetch_count                 -> accepted-request counter
// Revision : 1.0  initial release
// ============================================================================
module instr_mem_fetch #(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  DEPTH_WORDS = 64,
  parameter logic [DATA_WIDTH-1:0] FAULT_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_pc,
  output logic [1:0]            rsp_fault,
  output logic [31:0]           fetch_count
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int DEPTH_BYTES = DEPTH_WORDS * BYTES;
  localparam int IDX_W       = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  // Range checks are done one bit wider than the address so that a PC near
  // the top of the address space cannot wrap into the valid region.
  localparam logic [ADDR_WIDTH:0]   C_BYTES_X = (ADDR_WIDTH+1)'(BYTES);
  localparam logic [ADDR_WIDTH:0]   C_DEPTH_X = (ADDR_WIDTH+1)'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] C_BYTES_A = ADDR_WIDTH'(BYTES);

  // Program storage; deliberately not reset so the image survives rst.
  logic [7:0] mem [DEPTH_BYTES];

  logic                  w_req_mis;
  logic                  w_req_oor;
  logic                  w_ld_mis;
  logic                  w_ld_oor;
  logic                  w_load_ok;
  logic                  w_req_ready;
  logic                  w_accept;
  logic [1:0]            w_req_fault;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [IDX_W-1:0]      w_ld_idx [BYTES];

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_instr;
  logic [ADDR_WIDTH-1:0] r_rsp_pc;
  logic [1:0]            r_rsp_fault;
  logic                  r_load_err;
  logic [31:0]           r_fetch_count;

  assign w_req_mis   = (req_pc % C_BYTES_A) != '0;
  assign w_req_oor   = ({1'b0, req_pc} + C_BYTES_X) > C_DEPTH_X;
  assign w_ld_mis    = (load_addr % C_BYTES_A) != '0;
  assign w_ld_oor    = ({1'b0, load_addr} + C_BYTES_X) > C_DEPTH_X;
  assign w_req_fault = {w_req_oor, w_req_mis};
  assign w_load_ok   = load_en && !w_ld_mis && !w_ld_oor;

  // Single response register with no skid: a new request is taken only when
  // the register is empty or being drained this cycle, and never during a load.
  assign w_req_ready = !load_en && (!r_rsp_valid || rsp_ready);
  assign w_accept    = req_valid && w_req_ready;

  // Per-byte addresses; byte 0 (lowest address) maps to the MSB of the word.
  // Indices are only meaningful for fault-free accesses; faulted reads are
  // replaced by FAULT_WORD and faulted loads are suppressed.
  for (genvar b = 0; b < BYTES; b++) begin : g_byte
    logic [IDX_W-1:0] w_rd_idx;
    assign w_rd_idx    = req_pc[IDX_W-1:0] + IDX_W'(b);
    assign w_ld_idx[b] = load_addr[IDX_W-1:0] + IDX_W'(b);
    assign w_rd_word[DATA_WIDTH-1-8*b -: 8] = mem[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst && w_load_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        mem[w_ld_idx[b]] <= load_data[DATA_WIDTH-1-8*b -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_instr   <= '0;
      r_rsp_pc      <= '0;
      r_rsp_fault   <= 2'b00;
      r_load_err    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_load_err <= load_en && (w_ld_mis || w_ld_oor);
      if (w_accept) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_pc      <= req_pc;
        r_rsp_fault   <= w_req_fault;
        r_rsp_instr   <= (|w_req_fault) ? FAULT_WORD : w_rd_word;
        r_fetch_count <= r_fetch_count + 32'd1;
      end else if (rsp_ready) begin
        // Drained with nothing new: payload fields keep their last values.
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_instr   = r_rsp_instr;
  assign rsp_pc      = r_rsp_pc;
  assign rsp_fault   = r_rsp_fault;
  assign load_err    = r_load_err;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_fetch
// Purpose  : Self-checking bench for instr_mem_fetch: a directed vector table,
//            a counter-wrap sequence and randomized traffic compared with a
//            byte-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_mem_fetch;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          DEPTH_BYTES = 256;
  localparam logic [31:0] FW = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, load_en, req_valid, rsp_ready;
  logic [AW-1:0] load_addr, req_pc;
  logic [DW-1:0] load_data;
  logic          load_err, req_ready, rsp_valid;
  logic [DW-1:0] rsp_instr;
  logic [AW-1:0] rsp_pc;
  logic [1:0]    rsp_fault;
  logic [31:0]   fetch_count;

  int checks = 0;
  int errors = 0;

  instr_mem_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(64), .FAULT_WORD(FW)
  ) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_err(load_err),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mm [DEPTH_BYTES];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;
  logic [1:0]  m_fault = '0;
  logic        m_lerr  = 1'b0;
  logic [31:0] m_count = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fault_of(input logic [31:0] a);
    longint unsigned end_addr;
    end_addr = longint'(a) + 4;
    return {end_addr > DEPTH_BYTES, (a % 4) != 0};
  endfunction

  // Inputs are already driven; checks req_ready, advances one clock edge,
  // updates the model and checks every registered output.
  task automatic tick();
    logic exp_ready, acc;
    logic [1:0] f;
    #1;
    exp_ready = !load_en && (!m_valid || rsp_ready);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    acc = req_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_instr = 0; m_pc = 0; m_fault = 0; m_lerr = 0; m_count = 0;
    end else begin
      f = fault_of(load_addr);
      m_lerr = load_en && (f != 0);
      if (load_en && f == 0)
        for (int b = 0; b < 4; b++) mm[load_addr + b] = load_data[31-8*b -: 8];
      if (acc) begin
        f = fault_of(req_pc);
        m_valid = 1; m_pc = req_pc; m_fault = f; m_count = m_count + 1;
        if (f != 0) m_instr = FW;
        else m_instr = {mm[req_pc], mm[req_pc+1], mm[req_pc+2], mm[req_pc+3]};
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_instr", 64'(rsp_instr), 64'(m_instr));
    chk("rsp_pc", 64'(rsp_pc), 64'(m_pc));
    chk("rsp_fault", 64'(rsp_fault), 64'(m_fault));
    chk("load_err", 64'(load_err), 64'(m_lerr));
    chk("fetch_count", 64'(fetch_count), 64'(m_count));
  endtask

  typedef struct {
    logic        rst, ld_en;
    logic [31:0] ld_addr, ld_data;
    logic        rv;
    logic [31:0] pc;
    logic        rr;
    logic        e_ready, e_valid;
    logic [31:0] e_instr, e_pc;
    logic [1:0]  e_fault;
    logic        e_lerr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    for (int i = 0; i < DEPTH_BYTES; i++) mm[i] = 8'h00;

    //          rst ld  ld_addr        ld_data        rv pc             rr  rdy val instr          pc             flt lerr cnt
    tbl[0]  = '{1, 0, 32'h0,          32'h0,          0, 32'h0,          1,  1,  0, 32'h0,          32'h0,          0,  0,  0};
    tbl[1]  = '{0, 1, 32'h0,          32'hE3A01001,   0, 32'h0,          1,  0,  0, 32'h0,          32'h0,          0,  0,  0};
    tbl[2]  = '{0, 1, 32'h4,          32'hE3A02002,   0, 32'h0,          1,  0,  0, 32'h0,          32'h0,          0,  0,  0};
    tbl[3]  = '{0, 0, 32'h0,          32'h0,          1, 32'h0,          1,  1,  1, 32'hE3A01001,   32'h0,          0,  0,  1};
    tbl[4]  = '{0, 0, 32'h0,          32'h0,          1, 32'h4,          1,  1,  1, 32'hE3A02002,   32'h4,          0,  0,  2};
    tbl[5]  = '{0, 0, 32'h0,          32'h0,          1, 32'h2,          1,  1,  1, FW,             32'h2,          1,  0,  3};
    tbl[6]  = '{0, 0, 32'h0,          32'h0,          1, 32'h100,        1,  1,  1, FW,             32'h100,        2,  0,  4};
    tbl[7]  = '{0, 0, 32'h0,          32'h0,          1, 32'hFFFFFFFE,   1,  1,  1, FW,             32'hFFFFFFFE,   3,  0,  5};
    tbl[8]  = '{0, 1, 32'h6,          32'h11223344,   1, 32'h0,          1,  0,  0, FW,             32'hFFFFFFFE,   3,  1,  5};
    tbl[9]  = '{0, 0, 32'h0,          32'h0,          1, 32'h4,          1,  1,  1, 32'hE3A02002,   32'h4,          0,  0,  6};
    tbl[10] = '{0, 0, 32'h0,          32'h0,          1, 32'h0,          1,  1,  1, 32'hE3A01001,   32'h0,          0,  0,  7};
    tbl[11] = '{0, 0, 32'h0,          32'h0,          1, 32'h4,          0,  0,  1, 32'hE3A01001,   32'h0,          0,  0,  7};
    tbl[12] = '{0, 0, 32'h0,          32'h0,          1, 32'h4,          0,  0,  1, 32'hE3A01001,   32'h0,          0,  0,  7};
    tbl[13] = '{0, 0, 32'h0,          32'h0,          1, 32'h4,          0,  0,  1, 32'hE3A01001,   32'h0,          0,  0,  7};
    tbl[14] = '{0, 0, 32'h0,          32'h0,          1, 32'h4,          1,  1,  1, 32'hE3A02002,   32'h4,          0,  0,  8};
    tbl[15] = '{1, 1, 32'h0,          32'hFFFFFFFF,   0, 32'h0,          0,  0,  0, 32'h0,          32'h0,          0,  0,  0};
    tbl[16] = '{0, 0, 32'h0,          32'h0,          1, 32'h0,          1,  1,  1, 32'hE3A01001,   32'h0,          0,  0,  1};
    tbl[17] = '{0, 0, 32'h0,          32'h0,          0, 32'h0,          1,  1,  0, 32'hE3A01001,   32'h0,          0,  0,  1};

    // Initial reset without checks: outputs are undefined before it.
    rst = 1; load_en = 0; load_addr = 0; load_data = 0;
    req_valid = 0; req_pc = 0; rsp_ready = 1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; load_en = tbl[i].ld_en; load_addr = tbl[i].ld_addr;
      load_data = tbl[i].ld_data; req_valid = tbl[i].rv; req_pc = tbl[i].pc;
      rsp_ready = tbl[i].rr;
      #1;
      chk($sformatf("v%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
      tick();
      chk($sformatf("v%0d.rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_valid));
      chk($sformatf("v%0d.rsp_instr", i), 64'(rsp_instr), 64'(tbl[i].e_instr));
      chk($sformatf("v%0d.rsp_pc", i), 64'(rsp_pc), 64'(tbl[i].e_pc));
      chk($sformatf("v%0d.rsp_fault", i), 64'(rsp_fault), 64'(tbl[i].e_fault));
      chk($sformatf("v%0d.load_err", i), 64'(load_err), 64'(tbl[i].e_lerr));
      chk($sformatf("v%0d.fetch_count", i), 64'(fetch_count), 64'(tbl[i].e_cnt));
    end

    // Counter wrap: preset the counter to its maximum, then one accept.
    rst = 0; load_en = 0; req_valid = 0; rsp_ready = 1;
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_count;
    m_count = 32'hFFFF_FFFF;
    chk("wrap.preset", 64'(fetch_count), 64'h0000_0000_FFFF_FFFF);
    req_valid = 1; req_pc = 32'h4;
    tick();
    chk("wrap.zero", 64'(fetch_count), 64'h0);
    chk("wrap.instr", 64'(rsp_instr), 64'hE3A02002);

    // Fill the whole memory so every in-range random fetch has known data.
    req_valid = 0;
    for (int w = 0; w < DEPTH_BYTES / 4; w++) begin
      load_en = 1; load_addr = 32'(w * 4); load_data = $urandom;
      tick();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      load_en   = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       load_addr = $urandom;
        1:       load_addr = 32'($urandom_range(0, 263));
        default: load_addr = 32'($urandom_range(0, 63) * 4);
      endcase
      load_data = $urandom;
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       req_pc = $urandom;
        1:       req_pc = 32'($urandom_range(0, 263));
        2:       req_pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: req_pc = 32'($urandom_range(0, 63) * 4);
      endcase
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_fetch.md
# instr_mem_fetch

Parametrised, byte-addressed instruction memory with a valid/ready fetch interface, a word-load port for program image, and fault reporting. Sits between the PC/fetch stage and the decode pipeline register: accepts a PC request, returns the big-endian instruction word one cycle later, and holds it under downstream stall. Generalises the fixed 7-word, reset-loaded memory to configurable width/depth with back-pressure, runtime loading and misalignment/out-of-range detection.

## Interface
- ADDR_WIDTH, 32, width of byte address (pc, load_addr)
- DATA_WIDTH, 32, instruction width in bits; multiple of 8; BYTES = DATA_WIDTH/8
- DEPTH_WORDS, 64, memory depth in words; DEPTH_BYTES = DEPTH_WORDS*BYTES
- FAULT_WORD, 0, value driven on rsp_instr for a faulted fetch (bubble/NOP)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write one word of program image this cycle
- load_addr  in  ADDR_WIDTH  byte address of word to write
- load_data  in  DATA_WIDTH  word to write; MSB byte at lowest address
- load_err  out  1  one-cycle pulse: last load was misaligned or out of range (ignored)
- req_valid  in  1  fetch request present
- req_pc  in  ADDR_WIDTH  byte address to fetch
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready
- rsp_instr  out  DATA_WIDTH  fetched word, or FAULT_WORD on fault
- rsp_pc  out  ADDR_WIDTH  PC of the response
- rsp_fault  out  2  bit0 misaligned, bit1 out of range; 0 = good
- fetch_count  out  32  accepted-request counter, wraps 2^32-1 -> 0

## Operation
- Storage: byte array [0:DEPTH_BYTES-1]; contents not touched by rst (survive reset).
- Word assembly big-endian: rsp_instr = {mem[pc], mem[pc+1], …, mem[pc+BYTES-1]}.
- Load: when load_en, bytes of load_data written at load_addr..load_addr+BYTES-1 (MSB first). Misaligned (load_addr mod BYTES ≠ 0) or load_addr+BYTES > DEPTH_BYTES: no write, load_err=1 next cycle.
- load_en has priority: req_ready=0 in any cycle load_en=1.
- req_ready = !load_en && (!rsp_valid || rsp_ready) — single response register, no skid.
- On accept: compute fault, register rsp_pc=req_pc, rsp_instr (memory word or FAULT_WORD), rsp_fault, rsp_valid=1; fetch_count+1.
- Misaligned: bit0 set. Out of range (req_pc+BYTES > DEPTH_BYTES, computed at ADDR_WIDTH+1 bits so no wrap): bit1 set. Both may be set; any fault → FAULT_WORD.
- Response consumed with no new accept: rsp_valid→0; rsp_instr/rsp_pc/rsp_fault hold last values.
- rsp_valid=1 && rsp_ready=0: all rsp_* held stable, req_ready=0.
- Consume and accept in same cycle: new response replaces old, rsp_valid stays 1 (back-to-back, 1 fetch/cycle).

## Timing
- Read latency 1 cycle: request accepted at edge N → rsp_valid at N+1.
- Throughput 1 word/cycle with rsp_ready=1 and load_en=0.
- Load visible to a request accepted the cycle after the load edge; no bypass within the same cycle (impossible anyway as load blocks req).
- Reset (synchronous, checked before all else): rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_fault=0, load_err=0, fetch_count=0. Reset mid-stall discards pending response; load_en during rst ignored.
- req_ready combinational from load_en, rsp_valid, rsp_ready; all other outputs registered.

## Test plan
- Load words 0xE3A01001 @0, 0xE3A02002 @4; fetch pc=0 then 4 with rsp_ready=1 → rsp_instr 0xE3A01001 then 0xE3A02002 on consecutive cycles, rsp_fault=0, fetch_count=2.
- Fetch pc=0, hold rsp_ready=0 three cycles with req_valid=1 pc=4 → req_ready=0, rsp_instr stays 0xE3A01001; release → pc=4 accepted next edge, count increments once.
- Fetch pc=2 → rsp_fault=01, rsp_instr=FAULT_WORD; pc=DEPTH_BYTES (256) → rsp_fault=10; pc=0xFFFFFFFE → rsp_fault=11.
- load_en=1 with req_valid=1 → req_ready=0, no accept; load_addr=6 → load_err pulse, memory unchanged on refetch.
- Assert rst while rsp_valid=1 → next cycle all outputs 0, fetch_count=0; fetch pc=0 after reset still returns 0xE3A01001 (contents retained).
- Preset fetch_count via 2^32 accepts (or forced) → wraps to 0.
